// File: rtl/lc_ctrl_trans_seq.sv
// lc_ctrl_trans_seq: sequential life cycle transition checker.
// A request captures the redundant current/target state replicas and the
// transition count. Each replica is then checked against AllowedMatrix, one
// per cycle. The result is returned with a one-cycle acknowledge.
// Optional feature macro: LC_CTRL_VOLATILE_RAW_UNLOCK_EN. When it is defined,
// a volatile RAW -> TEST_UNLOCKED0 unlock is supported.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for req_i; results from the last request are held
// ST_CHECK | evaluating replica rep_q, one replica per cycle
// ST_DONE  | results valid, ack_o pulses
// ST_ERROR | illegal FSM encoding seen; terminal until reset
module lc_ctrl_trans_seq #(
  parameter int NumStates = 21,
  parameter int NumRep = 2,
  parameter int MaxCnt = 24,
  parameter logic [NumStates*NumStates-1:0] AllowedMatrix = '0,
  parameter logic [NumStates-1:0] LockedMask = '0,
  parameter int RawIdx = 0,
  parameter int TestUnlocked0Idx = 1,
  parameter int ScrapIdx = NumStates - 1,
  localparam int StW = $clog2(NumStates),
  localparam int CntW = $clog2(MaxCnt + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [NumRep*StW-1:0] cur_state_i,
  input  logic [NumRep*StW-1:0] tgt_state_i,
  input  logic [CntW-1:0]       cnt_i,
  input  logic                  tokens_valid_i,
  input  logic                  volatile_unlock_i,
  output logic                  busy_o,
  output logic                  ack_o,
  output logic [StW-1:0]        next_state_o,
  output logic [CntW-1:0]       next_cnt_o,
  output logic                  err_invalid_o,
  output logic                  err_oflw_o,
  output logic                  err_fsm_o
);

  localparam int RepW = (NumRep > 1) ? $clog2(NumRep) : 1;
  localparam int MatIdxW = (NumStates > 1) ? $clog2(NumStates * NumStates) : 1;

  // Every pair of codes differs in at least three bits. A single upset
  // therefore can never turn one legal state into another.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00011,
    ST_CHECK = 5'b01100,
    ST_DONE  = 5'b10101,
    ST_ERROR = 5'b11010
  } state_e;

  // The state register is kept as raw bits so that illegal codes can be
  // represented and then decoded as errors.
  logic [4:0] state_q;
  state_e     state_d;

  logic capture, step, finish;
  logic busy, ack, fsm_err;

  logic [NumRep*StW-1:0] cur_q, tgt_q;
  logic [CntW-1:0]       cnt_q;
  logic                  tokens_q;
  logic [RepW-1:0]       rep_q;
  logic                  inv_acc_q;
  logic                  err_invalid_q, err_oflw_q;
  logic [StW-1:0]        next_state_q;
  logic [CntW-1:0]       next_cnt_q;

  logic [StW-1:0]     cur_r, tgt_r, cur0, tgt0;
  logic               cur_r_ok, tgt_r_ok, tgt0_ok;
  logic [MatIdxW-1:0] mat_idx;
  logic               allowed;
  logic               vol, vol_rep_bad;
  logic               rep_bad, locked_bad, tgt_scrap;
  logic               invalid, oflw, any_err;
  logic [StW-1:0]     res_state;
  logic [CntW-1:0]    res_cnt;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and FSM-derived controls/outputs
  always_comb begin
    state_d = ST_ERROR;
    capture = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    busy    = 1'b1;
    ack     = 1'b0;
    fsm_err = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy    = 1'b0;
        fsm_err = 1'b0;
        state_d = ST_IDLE;
        if (req_i) begin
          capture = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        fsm_err = 1'b0;
        step    = 1'b1;
        state_d = ST_CHECK;
        if (rep_q == RepW'(NumRep - 1)) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        fsm_err = 1'b0;
        ack     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_ERROR;
    endcase
  end

  assign cur0     = cur_q[StW-1:0];
  assign tgt0     = tgt_q[StW-1:0];
  assign cur_r    = cur_q[rep_q*StW +: StW];
  assign tgt_r    = tgt_q[rep_q*StW +: StW];
  assign cur_r_ok = {1'b0, cur_r} < (StW+1)'(NumStates);
  assign tgt_r_ok = {1'b0, tgt_r} < (StW+1)'(NumStates);
  assign tgt0_ok  = {1'b0, tgt0} < (StW+1)'(NumStates);
  assign mat_idx  = MatIdxW'(cur_r) * MatIdxW'(NumStates) + MatIdxW'(tgt_r);
  // Out-of-range indices never reach the matrix lookup.
  assign allowed  = cur_r_ok && tgt_r_ok && AllowedMatrix[mat_idx];

`ifdef LC_CTRL_VOLATILE_RAW_UNLOCK_EN
  logic vol_q;

  // The volatile unlock request is taken at capture, like every other input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      vol_q <= 1'b0;
    else if (capture) vol_q <= volatile_unlock_i;
  end

  assign vol = vol_q;
  // Under volatile unlock, RAW -> TEST_UNLOCKED0 is the only accepted pair.
  assign vol_rep_bad = vol_q && ((cur_r != StW'(RawIdx)) ||
                                 (tgt_r != StW'(TestUnlocked0Idx)));
`else
  logic unused_vol;
  localparam int unused_idx = RawIdx + TestUnlocked0Idx;

  assign unused_vol  = volatile_unlock_i;
  assign vol         = 1'b0;
  assign vol_rep_bad = 1'b0;
`endif

  // Per-replica verdict and the final result. The final result is used on the
  // last Check cycle.
  always_comb begin
    rep_bad    = !cur_r_ok || !tgt_r_ok || (cur_r != cur0) || (tgt_r != tgt0) ||
                 !allowed || vol_rep_bad;
    locked_bad = tgt0_ok && LockedMask[tgt0] && !tokens_q;
    tgt_scrap  = (tgt0 == StW'(ScrapIdx));
    invalid    = inv_acc_q || rep_bad || locked_bad;
    oflw       = !vol && !tgt_scrap && (cnt_q >= CntW'(MaxCnt));
    any_err    = invalid || oflw;
    res_state  = any_err ? cur0 : tgt0;
    res_cnt    = cnt_q;
    if (!any_err && !vol) begin
      res_cnt = tgt_scrap ? CntW'(MaxCnt) : cnt_q + CntW'(1);
    end
  end

  // Capture registers, replica walk and result registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_q         <= '0;
      tgt_q         <= '0;
      cnt_q         <= '0;
      tokens_q      <= 1'b0;
      rep_q         <= '0;
      inv_acc_q     <= 1'b0;
      err_invalid_q <= 1'b0;
      err_oflw_q    <= 1'b0;
      next_state_q  <= '0;
      next_cnt_q    <= '0;
    end else if (capture) begin
      cur_q         <= cur_state_i;
      tgt_q         <= tgt_state_i;
      cnt_q         <= cnt_i;
      tokens_q      <= tokens_valid_i;
      rep_q         <= '0;
      inv_acc_q     <= 1'b0;
      err_invalid_q <= 1'b0;
      err_oflw_q    <= 1'b0;
    end else if (step) begin
      inv_acc_q <= inv_acc_q | rep_bad;
      if (finish) begin
        err_invalid_q <= invalid;
        err_oflw_q    <= oflw;
        next_state_q  <= res_state;
        next_cnt_q    <= res_cnt;
      end else begin
        rep_q <= rep_q + RepW'(1);
      end
    end
  end

  // In the error condition the outputs are forced to the scrap result.
  assign busy_o        = busy;
  assign ack_o         = ack;
  assign err_fsm_o     = fsm_err;
  assign err_invalid_o = fsm_err | err_invalid_q;
  assign err_oflw_o    = fsm_err ? 1'b0 : err_oflw_q;
  assign next_state_o  = fsm_err ? StW'(ScrapIdx) : next_state_q;
  assign next_cnt_o    = fsm_err ? CntW'(MaxCnt) : next_cnt_q;

endmodule

// File: tb/tb_lc_ctrl_trans_seq.sv
// Directed testbench for lc_ctrl_trans_seq with the default geometry
// (21 states, 2 replicas, MaxCnt 24).
module tb_lc_ctrl_trans_seq;

  localparam int NS = 21;
  localparam logic [NS*NS-1:0] MAT = ((NS*NS)'(1) << (0*NS + 1)) |
                                     ((NS*NS)'(1) << (0*NS + 2)) |
                                     ((NS*NS)'(1) << (0*NS + 5)) |
                                     ((NS*NS)'(1) << (0*NS + 20)) |
                                     ((NS*NS)'(1) << (3*NS + 5));
  localparam logic [NS-1:0] LOCK = NS'(1) << 2;
`ifdef LC_CTRL_VOLATILE_RAW_UNLOCK_EN
  localparam bit VolEn = 1'b1;
`else
  localparam bit VolEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [9:0] cur = '0;
  logic [9:0] tgt = '0;
  logic [4:0] cnt = '0;
  logic       tok = 1'b0;
  logic       vol = 1'b0;
  logic       busy, ack, err_inv, err_ofl, err_fsm;
  logic [4:0] nstate, ncnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lc_ctrl_trans_seq #(.AllowedMatrix(MAT), .LockedMask(LOCK)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req),
    .cur_state_i(cur), .tgt_state_i(tgt), .cnt_i(cnt),
    .tokens_valid_i(tok), .volatile_unlock_i(vol),
    .busy_o(busy), .ack_o(ack), .next_state_o(nstate), .next_cnt_o(ncnt),
    .err_invalid_o(err_inv), .err_oflw_o(err_ofl), .err_fsm_o(err_fsm)
  );

  task automatic chk(input string tag, input string name,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, name, obs, exp);
    end
  endtask

  task automatic run(input string tag,
                     input logic [4:0] c0, input logic [4:0] c1,
                     input logic [4:0] t0, input logic [4:0] t1,
                     input logic [4:0] cn, input logic tk, input logic vl,
                     input logic [4:0] ens, input logic [4:0] enc,
                     input logic einv, input logic eofl);
    int lat;
    @(negedge clk);
    cur = {c1, c0}; tgt = {t1, t0}; cnt = cn; tok = tk; vol = vl; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (!ack && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, "latency", lat, 3);
    chk(tag, "busy", busy, 1'b1);
    chk(tag, "next_state", nstate, ens);
    chk(tag, "next_cnt", ncnt, enc);
    chk(tag, "err_invalid", err_inv, einv);
    chk(tag, "err_oflw", err_ofl, eofl);
    chk(tag, "err_fsm", err_fsm, 1'b0);
    @(negedge clk);
    chk(tag, "ack_pulse", ack, 1'b0);
    chk(tag, "busy_after", busy, 1'b0);
    chk(tag, "hold_state", nstate, ens);
  endtask

  initial begin
    int n;
    // reset values
    #12;
    chk("reset", "busy", busy, 1'b0);
    chk("reset", "ack", ack, 1'b0);
    chk("reset", "next_state", nstate, 5'd0);
    chk("reset", "next_cnt", ncnt, 5'd0);
    chk("reset", "err_invalid", err_inv, 1'b0);
    chk("reset", "err_oflw", err_ofl, 1'b0);
    chk("reset", "err_fsm", err_fsm, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run("raw_to_tu0", 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    run("oflw_24", 0, 0, 5, 5, 24, 0, 0, 0, 24, 0, 1);
    run("cnt_23", 0, 0, 5, 5, 23, 0, 0, 5, 24, 0, 0);
    run("scrap_24", 0, 0, 20, 20, 24, 0, 0, 20, 24, 0, 0);
    run("scrap_30", 0, 0, 20, 20, 30, 0, 0, 20, 24, 0, 0);
    run("oflw_30", 0, 0, 5, 5, 30, 0, 0, 0, 30, 0, 1);
    run("rep_ok", 3, 3, 5, 5, 2, 0, 0, 5, 3, 0, 0);
    run("cur_mismatch", 3, 4, 5, 5, 2, 0, 0, 3, 2, 1, 0);
    run("tgt_range", 3, 3, 5, 25, 2, 0, 0, 3, 2, 1, 0);
    run("not_allowed", 3, 3, 1, 1, 2, 0, 0, 3, 2, 1, 0);
    run("locked_no_tok", 0, 0, 2, 2, 4, 0, 0, 0, 4, 1, 0);
    run("locked_tok", 0, 0, 2, 2, 4, 1, 0, 2, 5, 0, 0);
    run("vol_raw_tu0", 0, 0, 1, 1, 5, 0, 1, 1, VolEn ? 5'd5 : 5'd6, 0, 0);
    run("vol_raw_2", 0, 0, 2, 2, 5, 1, 1, VolEn ? 5'd0 : 5'd2,
        VolEn ? 5'd5 : 5'd6, VolEn, 0);

    // req held while busy, inputs changed during Check: one ack, original result
    @(negedge clk);
    cur = '0; tgt = {5'd1, 5'd1}; cnt = 5'd7; tok = 1'b0; vol = 1'b0; req = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack) n++;
      if (i == 0) begin
        tgt = {5'd2, 5'd2};
        cnt = 5'd0;
      end
      if (i == 2) req = 1'b0;
    end
    chk("held_req", "ack_count", n, 1);
    chk("held_req", "next_state", nstate, 5'd1);
    chk("held_req", "next_cnt", ncnt, 5'd8);

    // reset in the middle of Check
    cur = '0; tgt = {5'd5, 5'd5}; cnt = 5'd3; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_reset", "busy", busy, 1'b0);
    chk("mid_reset", "next_state", nstate, 5'd0);
    chk("mid_reset", "next_cnt", ncnt, 5'd0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) n++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) n++;
    end
    chk("mid_reset", "ack_count", n, 0);
    chk("mid_reset", "next_state_after", nstate, 5'd0);

    // illegal FSM encoding
    @(negedge clk);
    force dut.state_q = 5'b11111;
    #1;
    chk("fsm_illegal", "err_fsm", err_fsm, 1'b1);
    chk("fsm_illegal", "next_state", nstate, 5'd20);
    @(negedge clk);
    release dut.state_q;
    cur = '0; tgt = {5'd1, 5'd1}; cnt = '0; req = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) n++;
    end
    req = 1'b0;
    chk("fsm_sticky", "err_fsm", err_fsm, 1'b1);
    chk("fsm_sticky", "err_invalid", err_inv, 1'b1);
    chk("fsm_sticky", "busy", busy, 1'b1);
    chk("fsm_sticky", "ack_count", n, 0);
    chk("fsm_sticky", "next_state", nstate, 5'd20);
    chk("fsm_sticky", "next_cnt", ncnt, 5'd24);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("fsm_reset", "err_fsm", err_fsm, 1'b0);
    chk("fsm_reset", "busy", busy, 1'b0);
    run("after_recover", 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
